prod_accum: RTL and testbench

Downstream stage of the 16x16 unsigned multiplier. Consumes the 32-bit product stream over a valid/ready handshake and sums a fixed number of consecutive products (N_TERMS) into a wide accumulator. The finished sum is presented on a second valid/ready port and held until taken. This forms the accumulate half of a multiply-accumulate / dot-product datapath.

---
 rtl/prod_accum_if.sv | 33 +++
 rtl/prod_accum.sv | 116 +++++++++++
 tb/tb_prod_accum.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/prod_accum_if.sv
// Product-in / sum-out handshake bundle for prod_accum.
// slave is the accumulator side, master the producer/consumer side.
interface prod_accum_if #(
    parameter int ACC_W = 40
);
    logic [31:0]      prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             ovf;

    modport slave (
        input  prod_in,
        input  prod_valid,
        output prod_ready,
        output acc_out,
        output acc_valid,
        input  acc_ready,
        output ovf
    );

    modport master (
        output prod_in,
        output prod_valid,
        input  prod_ready,
        input  acc_out,
        input  acc_valid,
        output acc_ready,
        input  ovf
    );
endinterface

// File: rtl/prod_accum.sv
// Sums N_TERMS consecutive 32-bit products into an ACC_W-bit result.
// Optional PROD_ACCUM_SAT_EN: clamp to all-ones on carry-out instead of wrapping.
module prod_accum #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    prod_accum_if.slave   bus
);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [ACC_W-1:0] r_out;
    logic [ACC_W-1:0] w_out_nx;
    logic             r_valid;
    logic             w_valid_nx;
    logic             r_ovf;
    logic             w_ovf_nx;
    logic             r_ready;
    logic             w_fire;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_add;

    assign w_fire  = bus.prod_valid & r_ready;
    assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(bus.prod_in);
    assign w_carry = w_sum[ACC_W];

`ifdef PROD_ACCUM_SAT_EN
    assign w_add = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_add = w_sum[ACC_W-1:0];
`endif

    always_comb begin
        w_next     = r_state;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_out_nx   = r_out;
        w_valid_nx = r_valid;
        w_ovf_nx   = r_ovf;
        if (clear) begin
            w_acc_nx   = '0;
            w_cnt_nx   = '0;
            w_ovf_nx   = 1'b0;
            w_valid_nx = 1'b0;
            w_next     = S_ACCUM;
        end else begin
            unique case (r_state)
                S_IDLE: w_next = S_ACCUM;
                S_ACCUM: begin
                    if (w_fire) begin
                        w_acc_nx = w_add;
                        w_ovf_nx = r_ovf | w_carry;
                        if (r_cnt == LAST) begin
                            w_out_nx   = w_add;
                            w_valid_nx = 1'b1;
                            w_next     = S_DONE;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (r_valid && bus.acc_ready) begin
                        w_valid_nx = 1'b0;
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_ovf_nx   = 1'b0;
                        w_next     = S_ACCUM;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc_nx;
            r_cnt   <= w_cnt_nx;
            r_out   <= w_out_nx;
            r_valid <= w_valid_nx;
            r_ovf   <= w_ovf_nx;
            r_ready <= (w_next == S_ACCUM);
        end
    end

    assign bus.prod_ready = r_ready;
    assign bus.acc_out    = r_out;
    assign bus.acc_valid  = r_valid;
    assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: two N_TERMS=4 instances (40/33-bit) in
// lockstep plus an N_TERMS=1 instance.
module tb_prod_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tb_clear = 1'b0;
    logic c_clear = 1'b0;
    logic [31:0] tb_prod_in = '0;
    logic tb_prod_valid = 1'b0;
    logic tb_acc_ready = 1'b0;
    logic [31:0] c_prod_in = '0;
    logic c_prod_valid = 1'b0;
    logic c_acc_ready = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prod_accum_if #(.ACC_W(40)) if_a ();
    prod_accum_if #(.ACC_W(33)) if_b ();
    prod_accum_if #(.ACC_W(40)) if_c ();

    assign if_a.prod_in    = tb_prod_in;
    assign if_a.prod_valid = tb_prod_valid;
    assign if_a.acc_ready  = tb_acc_ready;
    assign if_b.prod_in    = tb_prod_in;
    assign if_b.prod_valid = tb_prod_valid;
    assign if_b.acc_ready  = tb_acc_ready;
    assign if_c.prod_in    = c_prod_in;
    assign if_c.prod_valid = c_prod_valid;
    assign if_c.acc_ready  = c_acc_ready;

    prod_accum #(.N_TERMS(4), .ACC_W(40)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(tb_clear), .bus(if_a)
    );
    prod_accum #(.N_TERMS(4), .ACC_W(33)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(tb_clear), .bus(if_b)
    );
    prod_accum #(.N_TERMS(1), .ACC_W(40)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(c_clear), .bus(if_c)
    );

    typedef struct {
        logic [31:0] p [4];
        logic [39:0] e40;
        logic        o40;
        logic [39:0] e33;
        logic        o33;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        logic rdy;
        bit done;
        done = 0;
        tb_prod_in = v;
        tb_prod_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = if_a.prod_ready;
            step();
            if (rdy) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got no accept expected accept of 0x%0h", v);
        end
    endtask

    task automatic push_c(input logic [31:0] v);
        logic rdy;
        bit done;
        done = 0;
        c_prod_in = v;
        c_prod_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = if_c.prod_ready;
            step();
            if (rdy) done = 1;
        end
        c_prod_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_c_timeout: got no accept expected accept of 0x%0h", v);
        end
    endtask

    task automatic handshake();
        tb_acc_ready = 1'b1;
        step();
        tb_acc_ready = 1'b0;
        chk("hs_valid_a", 64'(if_a.acc_valid), 64'd0);
        chk("hs_ready_a", 64'(if_a.prod_ready), 64'd1);
    endtask

    initial begin
        vecs[0].p = '{32'd3, 32'd5, 32'd7, 32'd9};
        vecs[0].e40 = 40'd24;            vecs[0].o40 = 1'b0;
        vecs[0].e33 = 40'd24;            vecs[0].o33 = 1'b0;
        vecs[1].p = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1].e40 = 40'h3_FFFF_FFFC;   vecs[1].o40 = 1'b0;
`ifdef PROD_ACCUM_SAT_EN
        vecs[1].e33 = 40'h1_FFFF_FFFF;   vecs[1].o33 = 1'b1;
`else
        vecs[1].e33 = 40'h1_FFFF_FFFC;   vecs[1].o33 = 1'b1;
`endif
        vecs[2].p = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2};
        vecs[2].e40 = 40'h1_0000_0003;   vecs[2].o40 = 1'b0;
        vecs[2].e33 = 40'h1_0000_0003;   vecs[2].o33 = 1'b0;
        vecs[3].p = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        vecs[3].e40 = 40'h2_FFFF_FFFD;   vecs[3].o40 = 1'b0;
`ifdef PROD_ACCUM_SAT_EN
        vecs[3].e33 = 40'h1_FFFF_FFFF;   vecs[3].o33 = 1'b1;
`else
        vecs[3].e33 = 40'h0_FFFF_FFFD;   vecs[3].o33 = 1'b1;
`endif
        vecs[4].p = '{32'd0, 32'd0, 32'd0, 32'd0};
        vecs[4].e40 = 40'd0;             vecs[4].o40 = 1'b0;
        vecs[4].e33 = 40'd0;             vecs[4].o33 = 1'b0;

        tb_prod_in = 32'd3;
        tb_prod_valid = 1'b1;
        step();
        step();
        chk("rst_ready", 64'(if_a.prod_ready), 64'd0);
        chk("rst_valid", 64'(if_a.acc_valid), 64'd0);
        chk("rst_out", 64'(if_a.acc_out), 64'd0);
        chk("rst_ovf", 64'(if_b.ovf), 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle_to_accum_ready", 64'(if_a.prod_ready), 64'd1);

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) chk("early_valid", 64'(if_a.acc_valid), 64'd0);
                push(vecs[r].p[k]);
            end
            chk($sformatf("v%0d_valid_a", r), 64'(if_a.acc_valid), 64'd1);
            chk($sformatf("v%0d_ready_a", r), 64'(if_a.prod_ready), 64'd0);
            chk($sformatf("v%0d_out_a", r), 64'(if_a.acc_out), 64'(vecs[r].e40));
            chk($sformatf("v%0d_ovf_a", r), 64'(if_a.ovf), 64'(vecs[r].o40));
            chk($sformatf("v%0d_out_b", r), 64'(if_b.acc_out), 64'(vecs[r].e33));
            chk($sformatf("v%0d_ovf_b", r), 64'(if_b.ovf), 64'(vecs[r].o33));
            handshake();
        end

        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        tb_prod_in = 32'd100;
        tb_prod_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 64'(if_a.acc_valid), 64'd1);
            chk("bp_out", 64'(if_a.acc_out), 64'd10);
            chk("bp_ready", 64'(if_a.prod_ready), 64'd0);
        end
        handshake();
        push(32'd100); push(32'd1); push(32'd1); push(32'd1);
        chk("bp_next_out", 64'(if_a.acc_out), 64'd103);
        handshake();

        push(32'd10); push(32'd20);
        tb_prod_in = 32'd99;
        tb_prod_valid = 1'b1;
        tb_clear = 1'b1;
        step();
        tb_clear = 1'b0;
        tb_prod_valid = 1'b0;
        chk("clr_valid", 64'(if_a.acc_valid), 64'd0);
        chk("clr_keep_out", 64'(if_a.acc_out), 64'd103);
        chk("clr_ready", 64'(if_a.prod_ready), 64'd1);
        push(32'd1); push(32'd1); push(32'd1); push(32'd1);
        chk("clr_next_out", 64'(if_a.acc_out), 64'd4);
        chk("clr_next_valid", 64'(if_a.acc_valid), 64'd1);
        handshake();

        push(32'hFFFF_FFFF); push(32'hFFFF_FFFF);
        push(32'hFFFF_FFFF); push(32'hFFFF_FFFF);
        tb_prod_valid = 1'b0;
        chk("pre_arst_valid", 64'(if_a.acc_valid), 64'd1);
        chk("pre_arst_ovf_b", 64'(if_b.ovf), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(if_a.acc_valid), 64'd0);
        chk("arst_out", 64'(if_a.acc_out), 64'd0);
        chk("arst_ready", 64'(if_a.prod_ready), 64'd0);
        chk("arst_ovf_b", 64'(if_b.ovf), 64'd0);
        chk("arst_out_b", 64'(if_b.acc_out), 64'd0);
        step();
        rst_n = 1'b1;

        push_c(32'd7);
        chk("n1_valid", 64'(if_c.acc_valid), 64'd1);
        chk("n1_out", 64'(if_c.acc_out), 64'd7);
        c_acc_ready = 1'b1;
        step();
        c_acc_ready = 1'b0;
        chk("n1_hs_valid", 64'(if_c.acc_valid), 64'd0);
        push_c(32'hFFFF_FFFF);
        chk("n1_out2", 64'(if_c.acc_out), 64'hFFFF_FFFF);
        chk("n1_ovf2", 64'(if_c.ovf), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
